// File: rtl/dram_arbiter.sv
// dram_arbiter
//   Round-robin arbiter that serialises single load/store accesses from
//   NUM_CORES cores onto one single-port synchronous data RAM. Each access
//   walks IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> DONE. The DONE cycle
//   pulses the one-hot ack of the granted core.
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req/we                per-core request level and store flag
//   addr/wdata            per-core address/store data, core i at [i*W +: W]
//   ack                   one-cycle completion pulse, one-hot or zero
//   rdata                 load data broadcast to all cores, held until next load
//   mem_en/mem_we         memory strobe (one cycle per access) and write enable
//   mem_addr/mem_wdata    memory address / write data
//   mem_rdata             memory read data, valid MEM_LAT cycles after mem_en
module dram_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int MEM_LAT   = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_CORES-1:0]          req,
  input  logic [NUM_CORES-1:0]          we,
  input  logic [NUM_CORES*ADDR_W-1:0]   addr,
  input  logic [NUM_CORES*DATA_W-1:0]   wdata,
  output logic [NUM_CORES-1:0]          ack,
  output logic [DATA_W-1:0]             rdata,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  // Counter runs MEM_LAT-1 down to 0 inside WAIT.
  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  // Access latched at grant time; cores may drop req afterwards.
  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } acc_t;

  logic [NUM_CORES-1:0][ADDR_W-1:0] addr_v;
  logic [NUM_CORES-1:0][DATA_W-1:0] wdata_v;
  assign addr_v  = addr;
  assign wdata_v = wdata;

  state_t           state;
  acc_t             cur;
  logic [IDX_W-1:0] ptr;
  logic [CNT_W-1:0] cnt;

  // Round-robin pick: scan offsets from the top down so the smallest
  // offset from ptr that is requesting wins without needing a break.
  logic [IDX_W-1:0] pick, cand;
  logic             pick_vld;
  always_comb begin
    pick     = '0;
    cand     = '0;
    pick_vld = 1'b0;
    for (int i = NUM_CORES-1; i >= 0; i--) begin
      cand = IDX_W'((int'(ptr) + i) % NUM_CORES);
      if (req[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  logic [NUM_CORES-1:0] grant_oh;
  assign grant_oh = {{(NUM_CORES-1){1'b0}}, 1'b1} << cur.idx;

  // Address/data come straight from the latch; they only matter with mem_en.
  assign mem_addr  = cur.addr;
  assign mem_wdata = cur.wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cur    <= '0;
      ptr    <= '0;
      cnt    <= '0;
      ack    <= '0;
      rdata  <= '0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
    end else begin
      case (state)
        IDLE: if (pick_vld) begin
          cur    <= '{idx: pick, we: we[pick], addr: addr_v[pick], wdata: wdata_v[pick]};
          mem_en <= 1'b1;
          mem_we <= we[pick];
          state  <= ISSUE;
        end
        ISSUE: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          cnt    <= CNT_W'(MEM_LAT-1);
          state  <= WAIT;
        end
        WAIT: begin
          if (cnt == '0) begin
            if (!cur.we) rdata <= mem_rdata;
            ack   <= grant_oh;
            state <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          ack   <= '0;
          ptr   <= (cur.idx == IDX_W'(NUM_CORES-1)) ? '0 : cur.idx + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter: a MEM_LAT=1 instance backed by a small
// RAM model and a MEM_LAT=3 instance whose mem_rdata changes every cycle.
module tb_dram_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // MEM_LAT=1 instance
  logic [3:0]       req, we, ack;
  logic [3:0][15:0] addr_v, wdata_v;
  logic [15:0]      rdata, mem_addr, mem_wdata, mem_rdata;
  logic             mem_en, mem_we;

  dram_arbiter #(.NUM_CORES(4), .ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr_v), .wdata(wdata_v),
    .ack(ack), .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

  // MEM_LAT=3 instance
  logic [3:0]       req3, we3, ack3;
  logic [3:0][15:0] addr3_v, wdata3_v;
  logic [15:0]      rdata3, mem_addr3, mem_wdata3, mem_rdata3;
  logic             mem_en3, mem_we3;

  dram_arbiter #(.NUM_CORES(4), .ADDR_W(16), .DATA_W(16), .MEM_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req(req3), .we(we3), .addr(addr3_v), .wdata(wdata3_v),
    .ack(ack3), .rdata(rdata3), .mem_en(mem_en3), .mem_we(mem_we3),
    .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3));

  // Value tagged with the current cycle, so the capture cycle is visible in rdata3.
  assign mem_rdata3 = {8'hC3, cyc[7:0]};

  // RAM model, one-cycle read latency
  logic [15:0] mem [0:255];
  always @(posedge clk)
    if (mem_en) begin
      if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[7:0]];
    end

  // Event logs sampled mid-cycle
  int          ack_n = 0, en_n = 0, we_hi_n = 0, en3_n = 0, en3_cyc = 0;
  int          ack_cyc [64];
  logic [3:0]  ack_v   [64];
  logic [15:0] ack_rd  [64];
  int          en_cyc  [64];
  logic        en_we   [64];
  logic [15:0] en_addr [64];
  logic [15:0] en_wd   [64];
  logic        multi_hot = 1'b0;

  always @(negedge clk) begin
    if (ack != 4'b0) begin
      if (ack_n < 64) begin
        ack_cyc[ack_n] = cyc; ack_v[ack_n] = ack; ack_rd[ack_n] = rdata;
      end
      ack_n++;
    end
    if ($countones(ack) > 1 || $countones(ack3) > 1) multi_hot = 1'b1;
    if (mem_en) begin
      if (en_n < 64) begin
        en_cyc[en_n] = cyc; en_we[en_n] = mem_we; en_addr[en_n] = mem_addr; en_wd[en_n] = mem_wdata;
      end
      en_n++;
    end
    if (mem_we) we_hi_n++;
    if (mem_en3) begin
      if (en3_n == 0) en3_cyc = cyc;
      en3_n++;
    end
  end

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  int t, n0, e0, w0;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    mem[8'h10] = 16'h1234;
    for (int i = 0; i < 4; i++) mem[8'h40 + i] = 16'hA000 + 16'(i);
    mem[8'h55] = 16'h5555;
    req = '0; we = '0; addr_v = '0; wdata_v = '0;
    req3 = '0; we3 = '0; addr3_v = '0; wdata3_v = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ack", ack, 4'h0);
    chk("rst_rdata", rdata, 16'h0);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 16'h0);
    chk("rst_mem_wdata", mem_wdata, 16'h0);
    repeat (2) tick;
    rst_n = 1'b1;
    tick;

    // Single load by core 2
    addr_v[2] = 16'h0010; we[2] = 1'b0; req = 4'b0100;
    t = cyc; e0 = en_n; n0 = ack_n;
    repeat (3) tick;
    chk("t1_ack", ack, 4'b0100);
    chk("t1_rdata", rdata, 16'h1234);
    req = 4'b0;
    tick;
    chk("t1_ack_low", ack, 4'b0);
    chk("t1_rdata_hold", rdata, 16'h1234);
    chk("t1_en_cnt", en_n - e0, 1);
    chk("t1_en_cyc", en_cyc[e0], t + 1);
    chk("t1_en_addr", en_addr[e0], 16'h0010);
    chk("t1_ack_cyc", ack_cyc[n0], t + 3);

    // Store by core 1, then load of the same address by core 3
    e0 = en_n; w0 = we_hi_n;
    addr_v[1] = 16'h0020; wdata_v[1] = 16'hBEEF; we[1] = 1'b1; req = 4'b0010;
    repeat (3) tick;
    chk("t3_st_ack", ack, 4'b0010);
    chk("t3_st_rdata", rdata, 16'h1234);
    req = 4'b0; we[1] = 1'b0;
    tick;
    addr_v[3] = 16'h0020; we[3] = 1'b0; req = 4'b1000;
    repeat (3) tick;
    chk("t3_ld_ack", ack, 4'b1000);
    chk("t3_ld_rdata", rdata, 16'hBEEF);
    req = 4'b0;
    tick;
    chk("t3_we_cycles", we_hi_n - w0, 1);
    chk("t3_st_we", en_we[e0], 1'b1);
    chk("t3_st_addr", en_addr[e0], 16'h0020);
    chk("t3_st_wdata", en_wd[e0], 16'hBEEF);
    chk("t3_ld_we", en_we[e0 + 1], 1'b0);

    // All four cores request continuously: grants 0,1,2,3,0 four cycles apart
    for (int i = 0; i < 4; i++) begin
      addr_v[i] = 16'h0040 + 16'(i); we[i] = 1'b0;
    end
    req = 4'hF; t = cyc; n0 = ack_n;
    repeat (19) tick;
    req = 4'b0;
    repeat (3) tick;
    chk("t2_ack_cnt", ack_n - n0, 5);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t2_cyc%0d", k), ack_cyc[n0 + k], t + 3 + 4 * k);
      chk($sformatf("t2_grant%0d", k), ack_v[n0 + k], 4'b0001 << (k % 4));
      chk($sformatf("t2_rdata%0d", k), ack_rd[n0 + k], 16'hA000 + 16'(k % 4));
    end

    // Core 0 drops req during WAIT
    addr_v[0] = 16'h0041; req = 4'b0001;
    e0 = en_n; n0 = ack_n;
    repeat (2) tick;
    req = 4'b0;
    tick;
    chk("t4_ack", ack, 4'b0001);
    chk("t4_rdata", rdata, 16'hA001);
    repeat (6) tick;
    chk("t4_en_cnt", en_n - e0, 1);
    chk("t4_ack_cnt", ack_n - n0, 1);

    // Reset during WAIT of a core 1 access (pointer is 1 here)
    addr_v[1] = 16'h0055; wdata_v[1] = 16'h1111; we[1] = 1'b0; req = 4'b0010;
    n0 = ack_n;
    repeat (2) tick;
    rst_n = 1'b0;
    #1;
    chk("t5_ack", ack, 4'b0);
    chk("t5_rdata", rdata, 16'h0);
    chk("t5_mem_en", mem_en, 1'b0);
    chk("t5_mem_we", mem_we, 1'b0);
    chk("t5_mem_addr", mem_addr, 16'h0);
    chk("t5_mem_wdata", mem_wdata, 16'h0);
    repeat (3) tick;
    chk("t5_no_ack", ack_n - n0, 0);
    addr_v[0] = 16'h0042;
    rst_n = 1'b1; req = 4'b0011;
    repeat (3) tick;
    chk("t5_first_grant", ack, 4'b0001);
    chk("t5_first_rdata", rdata, 16'hA002);
    req = 4'b0010;
    repeat (4) tick;
    chk("t5_second_grant", ack, 4'b0010);
    chk("t5_second_rdata", rdata, 16'h5555);
    req = 4'b0;
    repeat (2) tick;

    // MEM_LAT=3 single load by core 2
    addr3_v[2] = 16'h0077; we3[2] = 1'b0; req3 = 4'b0100;
    t = cyc;
    repeat (4) tick;
    chk("t6_ack_early", ack3, 4'b0);
    tick;
    chk("t6_ack", ack3, 4'b0100);
    chk("t6_rdata", rdata3, {8'hC3, 8'(t + 4)});
    chk("t6_en_cyc", en3_cyc, t + 1);
    chk("t6_en_addr_seen", mem_addr3, 16'h0077);
    req3 = 4'b0;
    tick;
    chk("t6_ack_low", ack3, 4'b0);
    chk("t6_en_cnt", en3_n, 1);

    chk("onehot_ack", multi_hot, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
